// File: rtl/cpu_oam_dma.sv
// ---------------------------------------------------------------------------
// cpu_oam_dma : $4014 sprite-DMA engine, copies one CPU page to the OAM port
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_oam_dma #(
   parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int          XFER_LEN      = 256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clock_en,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_w_data,
   input  logic        cpu_r_en,
   input  logic [7:0]  mem_r_data,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_w_data,
   output logic        mem_r_en,
   output logic        cpu_stall,
   output logic        dma_done
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic       parity_q, parity_d;
   logic       dma_done_q, dma_done_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         page_q     <= 8'h00;
         idx_q      <= 8'h00;
         parity_q   <= 1'b0;
         dma_done_q <= 1'b0;
      end else if (clock_en) begin
         state_q    <= state_d;
         page_q     <= page_d;
         idx_q      <= idx_d;
         parity_q   <= parity_d;
         dma_done_q <= dma_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      idx_d      = idx_q;
      parity_d   = ~parity_q;
      dma_done_d = 1'b0;
      mem_addr   = cpu_addr;
      mem_w_data = cpu_w_data;
      mem_r_en   = cpu_r_en;
      cpu_stall  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The trigger write still reaches memory through the pass-through.
            if (!cpu_r_en && (cpu_addr == TRIGGER_ADDR)) begin
               page_d  = cpu_w_data;
               idx_d   = 8'h00;
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            cpu_stall = 1'b1;
            mem_addr  = {page_q, 8'h00};
            mem_r_en  = 1'b1;
            // Reads must land on GET (parity 0) cycles.
            state_d   = parity_q ? S_READ : S_ALIGN;
         end
         S_ALIGN: begin
            cpu_stall = 1'b1;
            mem_addr  = {page_q, 8'h00};
            mem_r_en  = 1'b1;
            state_d   = S_READ;
         end
         S_READ: begin
            cpu_stall = 1'b1;
            mem_addr  = {page_q, idx_q};
            mem_r_en  = 1'b1;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            cpu_stall  = 1'b1;
            mem_addr   = OAM_DATA_ADDR;
            mem_r_en   = 1'b0;
            mem_w_data = mem_r_data;
            if (idx_q == LAST_IDX) begin
               state_d    = S_IDLE;
               dma_done_d = 1'b1;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dma_done = dma_done_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_cpu_oam_dma : randomized self-checking bench for cpu_oam_dma
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_oam_dma;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        clock_en;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_w_data;
   logic        cpu_r_en;
   logic [7:0]  mem_r_data;
   logic [15:0] mem_addr;
   logic [7:0]  mem_w_data;
   logic        mem_r_en;
   logic        cpu_stall;
   logic        dma_done;

   logic [7:0]  ram [0:65535];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          par;

   always #5 clock = ~clock;

   cpu_oam_dma dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .clock_en   (clock_en),
      .cpu_addr   (cpu_addr),
      .cpu_w_data (cpu_w_data),
      .cpu_r_en   (cpu_r_en),
      .mem_r_data (mem_r_data),
      .mem_addr   (mem_addr),
      .mem_w_data (mem_w_data),
      .mem_r_en   (mem_r_en),
      .cpu_stall  (cpu_stall),
      .dma_done   (dma_done)
   );

   // Memory model: latched read data; OAM port writes are not stored in RAM.
   always @(posedge clock) begin
      if (clock_en) begin
         if (mem_r_en) mem_r_data <= ram[mem_addr];
         else if (mem_addr != 16'h2004) ram[mem_addr] <= mem_w_data;
      end
   end

   // CPU cycle parity: GET on even enabled cycles since reset.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) par <= 1'b0;
      else if (clock_en) par <= ~par;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] safe_addr();
      logic [15:0] a;
      a = 16'($urandom);
      if (a == 16'h4014 || a == 16'h2004) a = 16'h0123;
      return a;
   endfunction

   // Runs one DMA; returns early after a mid-DMA reset when reset_at > 0.
   task automatic run_dma(input logic [7:0] page, input bit halt_par, input bit rand_ce,
                          input int freeze_after, input int reset_at);
      int          stalls = 0;
      int          writes = 0;
      int          freeze_left = 0;
      int          oam_after = 0;
      logic [15:0] last_rd = 16'hxxxx;
      logic [15:0] exp_rd;
      bit          ended = 1'b0;

      clock_en = 1'b1;
      cpu_addr = safe_addr(); cpu_r_en = 1'b1; cpu_w_data = 8'h00;
      // HALT cycle parity is the inverse of the trigger cycle parity.
      if (par == halt_par) next_cycle();
      cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = page;
      @(negedge clock);
      check("trig_pass_addr", mem_addr, 16'h4014);
      check("trig_stall", cpu_stall, 1'b0);
      next_cycle();

      for (int cyc = 0; cyc < 3000; cyc++) begin
         cpu_addr   = ($urandom_range(0, 7) == 0) ? 16'h4014 : 16'($urandom);
         cpu_w_data = 8'($urandom);
         cpu_r_en   = 1'($urandom);
         clock_en   = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (freeze_left > 0) begin
            clock_en = 1'b0;
            freeze_left--;
         end
         @(negedge clock);
         if (!cpu_stall) begin
            ended = 1'b1;
            break;
         end
         if (!clock_en && freeze_after >= 0 && writes == freeze_after) begin
            check("freeze_addr", mem_addr, {page, 8'(freeze_after)});
            check("freeze_ren", mem_r_en, 1'b1);
         end
         if (clock_en) begin
            stalls++;
            if (dma_done) check("done_in_stall", dma_done, 1'b0);
            if (!mem_r_en) begin
               exp_rd = {page, 8'(writes)};
               check("wr_addr", mem_addr, 16'h2004);
               check("rd_before_wr", last_rd, exp_rd);
               check("wr_data", mem_w_data, ram[exp_rd]);
               writes++;
               if (writes == freeze_after) freeze_left = 5;
            end else begin
               last_rd = mem_addr;
            end
         end
         next_cycle();
         if (reset_at > 0 && stalls == reset_at) begin
            reset_n = 1'b0;
            #1;
            check("rst_stall", cpu_stall, 1'b0);
            check("rst_pass_addr", mem_addr, cpu_addr);
            next_cycle();
            reset_n = 1'b1;
            clock_en = 1'b1;
            for (int k = 0; k < 20; k++) begin
               cpu_addr = safe_addr(); cpu_r_en = 1'($urandom); cpu_w_data = 8'($urandom);
               @(negedge clock);
               if (cpu_stall || (!mem_r_en && mem_addr == 16'h2004)) oam_after++;
               next_cycle();
            end
            check("post_rst_activity", oam_after, 0);
            return;
         end
      end

      check("dma_ended", ended, 1'b1);
      check("stall_len", stalls, halt_par ? 513 : 514);
      check("write_count", writes, 256);
      check("done_pulse", dma_done, 1'b1);
      clock_en = 1'b1; cpu_addr = 16'h0000; cpu_r_en = 1'b1;
      next_cycle();
      @(negedge clock);
      check("done_cleared", dma_done, 1'b0);
      check("idle_pass_addr", mem_addr, cpu_addr);
      next_cycle();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) ram[16'h0300 + i] = 8'(i) ^ 8'hA5;
      reset_n = 1'b0; clock_en = 1'b1;
      cpu_addr = 16'h1234; cpu_w_data = 8'h5A; cpu_r_en = 1'b0;
      #12;
      check("rst_stall", cpu_stall, 1'b0);
      check("rst_done", dma_done, 1'b0);
      check("rst_pass_addr", mem_addr, 16'h1234);
      check("rst_pass_data", mem_w_data, 8'h5A);
      check("rst_pass_ren", mem_r_en, 1'b0);
      next_cycle();
      reset_n = 1'b1;
      cpu_r_en = 1'b1;
      for (int i = 0; i < 3; i++) next_cycle();

      run_dma(8'h02, 1'b1, 1'b0, -1, 0);   // no align cycle
      run_dma(8'h02, 1'b0, 1'b0, -1, 0);   // one align cycle
      run_dma(8'h03, 1'($urandom), 1'b0, -1, 0);
      run_dma(8'h03, 1'($urandom), 1'b0, 10, 0);
      run_dma(8'($urandom), 1'($urandom), 1'b1, -1, 0);
      run_dma(8'h07, 1'b1, 1'b0, -1, 100);

      // Reads of $4014 and writes to $4015 never start a DMA.
      clock_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cpu_addr = (i == 0) ? 16'h4014 : 16'h4015;
         cpu_r_en = (i == 0);
         cpu_w_data = 8'($urandom);
         @(negedge clock);
         check("t6_pass_addr", mem_addr, cpu_addr);
         check("t6_pass_ren", mem_r_en, cpu_r_en);
         check("t6_pass_data", mem_w_data, cpu_w_data);
         next_cycle();
         cpu_addr = 16'h0010; cpu_r_en = 1'b1;
         @(negedge clock);
         check("t6_no_stall", cpu_stall, 1'b0);
         check("t6_no_done", dma_done, 1'b0);
         next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
